dsp_chain_accum: RTL and testbench
==================================

DSP_CHAIN_ACCUM -- requirements
Module: dsp_chain_accum

Interface
REQ-001 SHALL have parameter CHAINW, default 64: width of the DSP cascade bus sampled from the last DSP in a column.
REQ-002 SHALL have parameter ACCW, default 32: signed accumulator width.
REQ-003 SHALL have parameter ODATAW, default 8: signed requantized output width.
REQ-004 SHALL have parameter LAT, default 3: DSP cycles from operand issue to valid chain value.
REQ-005 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two.
REQ-006 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: operands issued to the column head this cycle.
REQ-009 SHALL have port in_first, input, 1: issued beat starts a dot product.
REQ-010 SHALL have port in_last, input, 1: issued beat ends a dot product.
REQ-011 SHALL have port in_ready, output, 1: issuer may assert in_valid this cycle.
REQ-012 SHALL have port chainin, input, CHAINW: cascade sum from the column tail.
REQ-013 SHALL have port shift, input, 5: arithmetic right-shift amount, quasi-static.
REQ-014 SHALL have port out_valid, output, 1: FIFO head holds a result.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the head.
REQ-016 SHALL have port out_data, output, ODATAW: requantized result at the FIFO head.
REQ-017 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-018 SHALL carry {valid,first,last} of each beat accepted (in_valid & in_ready) through an LAT-stage delay line; chainin is sampled when the delayed valid is high, LAT cycles after issue.
REQ-019 SHALL take the sample as chainin[ACCW-1:0], interpreted as signed.
REQ-020 SHALL implement a two-state FSM: IDLE and ACCUM.
REQ-021 In IDLE, a sample with first SHALL load acc with the sample; the FSM then goes to ACCUM unless last is also set.
REQ-022 In ACCUM, a sample without first SHALL add to acc, saturating to the signed ACCW range.
REQ-023 A sample without first in IDLE SHALL be treated as first and set err.
REQ-024 A sample with first in ACCUM SHALL restart acc with the sample and set err.
REQ-025 A sample with last SHALL register the final sum into a requant stage and return the FSM to IDLE.
REQ-026 The requant stage SHALL compute (sum + (shift>0 ? 2^(shift-1) : 0)) >>> shift, saturate to signed ODATAW, and write the result to the FIFO on the next edge.
REQ-027 out_valid SHALL rise 2 cycles after the last beat's sample edge, i.e. LAT+2 cycles after that beat's issue.
REQ-028 A FIFO pop SHALL occur on out_valid & out_ready.
REQ-029 Results SHALL leave the FIFO in issue order.
REQ-030 A push and a pop in the same cycle SHALL leave the occupancy unchanged, including when the FIFO is full.
REQ-031 in_ready SHALL equal (fifo_count + pending) < DEPTH, where pending is the number of last-flagged beats in the delay line plus requant stage; in_ready SHALL be driven from registers only.
REQ-032 in_valid while in_ready is low SHALL be ignored.
REQ-033 A FIFO push while full SHALL never occur.
REQ-034 err SHALL clear only on reset.

Reset
REQ-035 While rst is low, the block SHALL hold the FSM in IDLE and clear acc, the delay line, the requant stage, FIFO pointers and count, and err.
REQ-036 While rst is low, outputs SHALL be: out_valid=0, out_data=0, err=0, in_ready=1.
REQ-037 Release of rst mid-operation SHALL produce no output for beats issued before the reset.

Verification (LAT=3, DEPTH=4, ACCW=32, ODATAW=8)
REQ-038 Basic: beats chainin 10, 20, -5 (first on beat 1, last on beat 3), shift=0 -> out_data=25, out_valid high exactly 5 cycles after beat-3 issue.
REQ-039 Requant: single first+last beats 200, -300, 5, -5 with shift 0, 0, 1, 1 -> outputs 127, -128, 3, -2.
REQ-040 Backpressure: out_ready=0, issue 6 single-beat products of values 1-6 -> in_ready low after the 4th accepted beat, only 1-4 accepted; out_ready=1 -> 1, 2, 3, 4 in order, then in_ready returns high.
REQ-041 Protocol error: beat 7 without first in IDLE, then last beat 3 -> out_data=10, err=1 and err stays high.
REQ-042 Accumulator saturation: beats 0x7FFFFFF0 then 0x100 (last), shift=24 -> sum held at 2^31-1, out_data=127.
REQ-043 Reset mid-flight: rst low for 1 cycle with 2 beats in the delay line -> out_valid=0, in_ready=1, err=0 immediately; no output appears after release.

Source files
------------

// File: rtl/dsp_chain_accum.sv
// Accumulates DSP cascade sums over a dot product, requantizes the final sum
// and buffers results in a small FIFO with credit-style issue throttling.
module dsp_chain_accum #(
   parameter int CHAINW = 64,
   parameter int ACCW   = 32,
   parameter int ODATAW = 8,
   parameter int LAT    = 3,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_first,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [CHAINW-1:0] chainin,
   input  logic [4:0]        shift,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ODATAW-1:0] out_data,
   output logic              err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                   state, state_n;
   logic [LAT-1:0]           dv, df, dl, dv_n, df_n, dl_n;
   logic signed [ACCW-1:0]   acc, acc_n, rq_sum, rq_sum_n, sample, addsum;
   logic signed [ACCW:0]     wide;
   logic                     rq_valid, rq_valid_n, errq, err_n;
   logic                     accept, push, pop, rdy, rdy_n;
   logic [AW-1:0]            wptr, rptr;
   logic [CW-1:0]            count, count_n;
   logic [15:0]              occ_n;
   logic signed [ACCW+1:0]   rnd, rx, shd, qmax, qmin;
   logic [ODATAW-1:0]        q;
   logic [ODATAW-1:0]        mem [DEPTH];
   logic                     chain_unused;

   assign chain_unused = ^chainin[CHAINW-1:ACCW];
   assign sample       = chainin[ACCW-1:0];
   assign accept       = in_valid & rdy;
   assign push         = rq_valid;
   assign out_valid    = (count != '0);
   assign pop          = out_valid & out_ready;
   assign in_ready     = rdy;
   assign err          = errq;
   assign out_data     = out_valid ? mem[rptr] : '0;

   // Saturating add of the new chain sample onto the running sum.
   always_comb begin
      wide   = {acc[ACCW-1], acc} + {sample[ACCW-1], sample};
      addsum = wide[ACCW-1:0];
      if (wide[ACCW] != wide[ACCW-1])
         addsum = wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
   end

   always_comb begin
      dv_n    = '0;
      df_n    = '0;
      dl_n    = '0;
      dv_n[0] = accept;
      df_n[0] = accept & in_first;
      dl_n[0] = accept & in_last;
      for (int unsigned i = 1; i < LAT; i++) begin
         dv_n[i] = dv[i-1];
         df_n[i] = df[i-1];
         dl_n[i] = dl[i-1];
      end
   end

   always_comb begin
      state_n    = state;
      acc_n      = acc;
      err_n      = errq;
      rq_valid_n = 1'b0;
      rq_sum_n   = rq_sum;
      if (dv[LAT-1]) begin
         if (state == IDLE) begin
            acc_n = sample;
            if (!df[LAT-1]) err_n = 1'b1;
         end else if (df[LAT-1]) begin
            acc_n = sample;
            err_n = 1'b1;
         end else begin
            acc_n = addsum;
         end
         if (dl[LAT-1]) begin
            rq_valid_n = 1'b1;
            rq_sum_n   = acc_n;
            state_n    = IDLE;
         end else begin
            state_n = ACCUM;
         end
      end
   end

   // in_ready is registered from next-state occupancy so it matches the
   // current fifo_count + pending without a combinational path.
   always_comb begin
      count_n = count + CW'(push) - CW'(pop);
      occ_n   = 16'(count_n) + 16'(rq_valid_n);
      for (int unsigned i = 0; i < LAT; i++)
         occ_n = occ_n + 16'(dl_n[i]);
      rdy_n = (occ_n < 16'(DEPTH));
   end

   always_comb begin
      rnd = '0;
      if (shift != 5'd0)
         rnd = (ACCW+2)'(1) << (shift - 5'd1);
      rx   = {{2{rq_sum[ACCW-1]}}, rq_sum};
      rx   = rx + rnd;
      shd  = rx >>> shift;
      qmax = {{(ACCW+3-ODATAW){1'b0}}, {(ODATAW-1){1'b1}}};
      qmin = {{(ACCW+3-ODATAW){1'b1}}, {(ODATAW-1){1'b0}}};
      q    = shd[ODATAW-1:0];
      if (shd > qmax)      q = qmax[ODATAW-1:0];
      else if (shd < qmin) q = qmin[ODATAW-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         acc      <= '0;
         dv       <= '0;
         df       <= '0;
         dl       <= '0;
         rq_valid <= 1'b0;
         rq_sum   <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         errq     <= 1'b0;
         rdy      <= 1'b1;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         dv       <= dv_n;
         df       <= df_n;
         dl       <= dl_n;
         rq_valid <= rq_valid_n;
         rq_sum   <= rq_sum_n;
         count    <= count_n;
         errq     <= err_n;
         rdy      <= rdy_n;
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= q;
   end

endmodule

// File: tb/tb_dsp_chain_accum.sv
// Scoreboard bench for dsp_chain_accum: a DSP-column model feeds chainin, a
// behavioural dot-product model predicts results, a monitor checks each pop.
module tb_dsp_chain_accum;

   localparam int CHAINW = 64;
   localparam int ACCW   = 32;
   localparam int ODATAW = 8;
   localparam int LAT    = 3;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_first, in_last, in_ready;
   logic [CHAINW-1:0] chainin;
   logic [4:0]        shift;
   logic              out_valid, out_ready, err;
   logic [ODATAW-1:0] out_data;

   always #5 clk = ~clk;

   dsp_chain_accum #(
      .CHAINW(CHAINW), .ACCW(ACCW), .ODATAW(ODATAW), .LAT(LAT), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_ready(in_ready),
      .chainin(chainin), .shift(shift),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err(err)
   );

   int checks = 0;
   int errors = 0;
   int expq[$];
   int mon_exp;

   // Model of the DSP column: the issued value reaches the tail LAT cycles later.
   logic [CHAINW-1:0] pipe [LAT];
   logic [31:0]       cur_val;
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= {$urandom(), (in_valid && in_ready) ? cur_val : $urandom()};
   end
   assign chainin = pipe[LAT-1];

   bit     m_inprod = 1'b0;
   longint m_sum    = 0;
   bit     m_err    = 1'b0;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int requant(input longint s, input int sh);
      longint r;
      r = s;
      if (sh > 0) r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
      return int'(clamp(r, -128, 127));
   endfunction

   // Issues one beat; called and returns at posedge+1.
   task automatic beat(input int v, input bit f, input bit l, output bit acc);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      cur_val  = v;
      acc      = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      if (acc) begin
         if (f || !m_inprod) begin
            if (!f || m_inprod) m_err = 1'b1;
            m_sum = longint'(v);
         end else begin
            m_sum = clamp(m_sum + longint'(v), -(longint'(1) <<< 31), (longint'(1) <<< 31) - 1);
         end
         if (l) begin
            expq.push_back(requant(m_sum, int'(shift)));
            m_inprod = 1'b0;
         end else begin
            m_inprod = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
         end else begin
            mon_exp = expq.pop_front();
            chk("out_data", longint'($signed(out_data)), longint'(mon_exp));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit a;
      bit accs[6];
      int k, seen;
      bit done;
      int v2[4] = '{200, -300, 5, -5};
      int s2[4] = '{0, 0, 1, 1};

      rst = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      out_ready = 1'b1; shift = '0; cur_val = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b1;
      idle(2);

      // Basic three-beat product and result latency
      beat(10, 1, 0, a);
      beat(20, 0, 0, a);
      beat(-5, 0, 1, a);
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin k = i; break; end
      end
      chk("latency", k, 5);
      @(posedge clk); #1;
      idle(5);

      for (int i = 0; i < 4; i++) begin
         shift = s2[i][4:0];
         beat(v2[i], 1, 1, a);
         idle(8);
      end

      // Backpressure: only DEPTH results may be outstanding
      shift = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         beat(i + 1, 1, 1, accs[i]);
         chk($sformatf("accepted_%0d", i + 1), accs[i], (i < 4) ? 1 : 0);
      end
      idle(6);
      chk("full_out_valid", out_valid, 1);
      chk("full_in_ready", in_ready, 0);
      out_ready = 1'b1;
      idle(8);
      chk("drained_in_ready", in_ready, 1);
      chk("drained_queue", expq.size(), 0);
      chk("err_clean", err, 0);

      // Missing first in IDLE
      beat(7, 0, 0, a);
      beat(3, 0, 1, a);
      idle(8);
      chk("err_set", err, 1);

      // Accumulator saturation
      shift = 5'd24;
      beat(32'h7FFF_FFF0, 1, 0, a);
      beat(32'h0000_0100, 0, 1, a);
      idle(8);
      chk("err_sticky", err, m_err);

      // Randomized products with random consumer stalls
      shift = 5'd6;
      idle(2);
      done = 1'b0;
      fork
         begin
            for (int p = 0; p < 60; p++) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  int v, tries;
                  bit f, l;
                  v = ($urandom_range(0, 19) == 0) ? int'($urandom()) : int'($urandom_range(0, 65535)) - 32768;
                  f = (b == 0) && ($urandom_range(0, 19) != 0);
                  l = (b == len - 1);
                  tries = 0;
                  do begin
                     beat(v, f, l, a);
                     tries++;
                  end while (!a && tries < 200);
                  if (!a) chk("issue_timeout", 0, 1);
                  if ($urandom_range(0, 3) == 0) idle(1);
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      idle(20);
      chk("random_drained", expq.size(), 0);
      chk("err_before_reset", err, m_err);

      // Reset with beats still in flight
      shift = '0;
      beat(50, 1, 1, a);
      beat(60, 1, 1, a);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_err", err, 0);
      expq.delete();
      m_inprod = 1'b0;
      m_err = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      @(posedge clk); #1;
      chk("no_output_after_reset", seen, 0);
      chk("err_after_reset", err, 0);
      chk("final_queue", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
